// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the down-counter that must hold the value WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Datapath for the shift-and-add multiplier: shifted multiplicand (ra),
// remaining multiplier bits (rb), accumulator (acc) and step counter (cnt).
// load captures operands; step retires one multiplier bit.
module mult_shift_add_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               last,
  output logic               rb_hi_zero
);
  import mult_pkg::*;

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  logic [2*WIDTH-1:0] ra;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rb;
  logic [CW-1:0]      cnt;

  // Accumulator value after the current step; acc and ra are 2*WIDTH wide so
  // the sum can never overflow.
  assign acc_next   = rb[0] ? (acc + ra) : acc;
  assign last       = (cnt == CW'(1));
  assign rb_hi_zero = (rb[WIDTH-1:1] == '0);

  // Operand capture on load, one shift-and-add iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are individual flops, not a RAM, so clearing them on reset
    // is free and keeps the internal state fully known after rst_n.
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      ra  <= {{WIDTH{1'b0}}, a};
      rb  <= b;
      acc <= '0;
      cnt <= CNT_INIT;
    end else if (step) begin
      acc <= acc_next;
      ra  <= ra << 1;
      rb  <= rb >> 1;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one multiplier bit per clock.
// Handshake: start (IDLE only), abort (RUN only), busy, one-cycle done pulse.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as no set multiplier bits
// remain above the one being retired, so latency follows the msb of b.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import mult_pkg::*;

  state_t             state, state_nxt;
  logic               load, step, finish, end_now;
  logic               last, rb_hi_zero;
  logic [2*WIDTH-1:0] acc_next;

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .a          (a),
    .b          (b),
    .acc_next   (acc_next),
    .last       (last),
    .rb_hi_zero (rb_hi_zero)
  );

`ifdef MULT_EARLY_EXIT_EN
  assign end_now = last | rb_hi_zero;
`else
  assign end_now = last;
  logic unused_rb_hi_zero;
  assign unused_rb_hi_zero = rb_hi_zero;
`endif

  assign busy = (state == RUN);

  // Next-state and datapath control; abort outranks both start and finish.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (end_now) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Completion pulse and held result; product only moves on a real finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= finish;
      if (finish) product <= acc_next;
    end
  end

endmodule
